// File: rtl/cdr_pkg.sv
// Shared types and default parameters for the CDR feedback-path blocks.
package cdr_pkg;

   typedef enum logic [1:0] {LS_IDLE, LS_ACQ, LS_LOCK, LS_HOLD} lock_state_t;

   localparam int unsigned DIV_W_D       = 8;
   localparam int unsigned CNT_W_D       = 16;
   localparam int unsigned WIN_REF_D     = 32;
   localparam int unsigned TOL_D         = 2;
   localparam int unsigned LOCK_WINS_D   = 4;
   localparam int unsigned UNLOCK_WINS_D = 2;

   // Bits needed to hold the values 0..maxval.
   function automatic int unsigned cnt_w(input int unsigned maxval);
      if (maxval < 2) return 1;
      return $clog2(maxval + 1);
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, plus a third flop for a
// one-cycle rising-edge pulse in the clk domain.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise_c
);

   logic s1, s2, s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise_c = s2 & ~s3;

endmodule

// File: rtl/fbdiv_lock_detect.sv
// Feedback divider (ck / div_n -> divclk) with a refclk-window frequency
// measurement and a hysteretic lock-qualification FSM.
module fbdiv_lock_detect
   import cdr_pkg::*;
#(
   parameter int unsigned DIV_W       = DIV_W_D,
   parameter int unsigned CNT_W       = CNT_W_D,
   parameter int unsigned WIN_REF     = WIN_REF_D,
   parameter int unsigned TOL         = TOL_D,
   parameter int unsigned LOCK_WINS   = LOCK_WINS_D,
   parameter int unsigned UNLOCK_WINS = UNLOCK_WINS_D
) (
   input  logic             ck,
   input  logic             rst,
   input  logic             en,
   input  logic             refclk,
   input  logic [DIV_W-1:0] div_n,
   output logic             divclk,
   output logic [CNT_W-1:0] ref_period,
   output logic             win_valid,
   output logic             locked,
   output lock_state_t      lock_state
);

   localparam int unsigned RCNT_W = cnt_w(WIN_REF - 1);
   localparam int unsigned GCNT_W = cnt_w(LOCK_WINS);
   localparam int unsigned BCNT_W = cnt_w(UNLOCK_WINS);

   logic ref_rise_c;

   sync_edge_det u_ref_sync (
      .clk    (ck),
      .rst    (rst),
      .d      (refclk),
      .rise_c (ref_rise_c)
   );

   // ---------------- divider ----------------
   logic [DIV_W-1:0] dcnt, ncur;
   logic [DIV_W-1:0] n_req_c, dcnt_nxt_c, n_nxt_c;
   logic             wrap_c;

   always_comb begin
      n_req_c    = (div_n < DIV_W'(2)) ? DIV_W'(2) : div_n;
      wrap_c     = (dcnt == ncur - DIV_W'(1));
      dcnt_nxt_c = wrap_c ? '0 : dcnt + DIV_W'(1);
      n_nxt_c    = wrap_c ? n_req_c : ncur;
   end

   // divclk is produced from the next count so it stays phase-aligned with dcnt.
   always_ff @(posedge ck) begin
      if (rst) begin
         dcnt   <= '0;
         ncur   <= DIV_W'(2);
         divclk <= 1'b0;
      end else if (!en) begin
         dcnt   <= '0;
         ncur   <= n_req_c;
         divclk <= 1'b0;
      end else begin
         dcnt   <= dcnt_nxt_c;
         ncur   <= n_nxt_c;
         divclk <= (dcnt_nxt_c < (n_nxt_c >> 1));
      end
   end

   // ---------------- measurement window ----------------
   logic              armed, good_q;
   logic [CNT_W-1:0]  wcnt, exp_q;
   logic [RCNT_W-1:0] rcnt;
   logic [CNT_W-1:0]  exp_c, meas_c, diff_c;
   logic              good_c, sat_c, win_done_c;

   always_comb begin
      exp_c      = CNT_W'(WIN_REF) * CNT_W'(ncur);
      meas_c     = wcnt + CNT_W'(1);
      diff_c     = (meas_c >= exp_q) ? (meas_c - exp_q) : (exp_q - meas_c);
      good_c     = (diff_c <= CNT_W'(TOL));
      sat_c      = armed && (wcnt == '1);
      win_done_c = armed && ref_rise_c && (rcnt == RCNT_W'(WIN_REF - 1));
   end

   // A stuck refclk ends the window as bad and disarms until the next edge.
   always_ff @(posedge ck) begin
      if (rst) begin
         armed      <= 1'b0;
         wcnt       <= '0;
         rcnt       <= '0;
         exp_q      <= '0;
         ref_period <= '0;
         win_valid  <= 1'b0;
         good_q     <= 1'b0;
      end else begin
         win_valid <= 1'b0;
         if (!en) begin
            armed <= 1'b0;
            wcnt  <= '0;
            rcnt  <= '0;
         end else if (sat_c) begin
            ref_period <= '1;
            win_valid  <= 1'b1;
            good_q     <= 1'b0;
            armed      <= 1'b0;
            wcnt       <= '0;
            rcnt       <= '0;
         end else if (!armed) begin
            if (ref_rise_c) begin
               armed <= 1'b1;
               exp_q <= exp_c;
            end
            wcnt <= '0;
            rcnt <= '0;
         end else if (win_done_c) begin
            ref_period <= meas_c;
            win_valid  <= 1'b1;
            good_q     <= good_c;
            wcnt       <= '0;
            rcnt       <= '0;
            exp_q      <= exp_c;
         end else begin
            wcnt <= wcnt + CNT_W'(1);
            if (ref_rise_c) rcnt <= rcnt + RCNT_W'(1);
         end
      end
   end

   // ---------------- lock FSM ----------------
   logic [GCNT_W-1:0] gcnt;
   logic [BCNT_W-1:0] bcnt;

   always_ff @(posedge ck) begin
      if (rst || !en) begin
         lock_state <= LS_IDLE;
         gcnt       <= '0;
         bcnt       <= '0;
         locked     <= 1'b0;
      end else begin
         case (lock_state)
            LS_IDLE: begin
               lock_state <= LS_ACQ;
               gcnt       <= '0;
               bcnt       <= '0;
               locked     <= 1'b0;
            end
            LS_ACQ: begin
               if (win_valid) begin
                  if (!good_q) begin
                     gcnt <= '0;
                  end else if (gcnt == GCNT_W'(LOCK_WINS - 1)) begin
                     lock_state <= LS_LOCK;
                     locked     <= 1'b1;
                     gcnt       <= '0;
                  end else begin
                     gcnt <= gcnt + GCNT_W'(1);
                  end
               end
            end
            LS_LOCK: begin
               if (win_valid && !good_q) begin
                  lock_state <= LS_HOLD;
                  bcnt       <= BCNT_W'(1);
               end
            end
            LS_HOLD: begin
               if (win_valid) begin
                  if (good_q) begin
                     lock_state <= LS_LOCK;
                     bcnt       <= '0;
                  end else if (bcnt == BCNT_W'(UNLOCK_WINS - 1)) begin
                     lock_state <= LS_ACQ;
                     locked     <= 1'b0;
                     gcnt       <= '0;
                     bcnt       <= '0;
                  end else begin
                     bcnt <= bcnt + BCNT_W'(1);
                  end
               end
            end
            default: begin
               lock_state <= LS_IDLE;
               locked     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fbdiv_lock_detect.sv
// Self-checking bench for fbdiv_lock_detect: vector table + window scoreboard,
// plus hand sequences for lock loss and counter saturation.
module tb_fbdiv_lock_detect;
   import cdr_pkg::*;

   logic        ck = 1'b0;
   logic        rst = 1'b1;
   logic        en_a = 1'b0;
   logic        en_b = 1'b0;
   logic        refclk = 1'b0;
   logic [7:0]  div_n = 8'd4;

   logic        divclk_a, win_valid_a, locked_a;
   logic [15:0] ref_period_a;
   lock_state_t lock_state_a;
   logic        divclk_b, win_valid_b, locked_b;
   logic [7:0]  ref_period_b;
   lock_state_t lock_state_b;

   fbdiv_lock_detect u_dut_a (
      .ck(ck), .rst(rst), .en(en_a), .refclk(refclk), .div_n(div_n),
      .divclk(divclk_a), .ref_period(ref_period_a), .win_valid(win_valid_a),
      .locked(locked_a), .lock_state(lock_state_a)
   );

   fbdiv_lock_detect #(.CNT_W(8)) u_dut_b (
      .ck(ck), .rst(rst), .en(en_b), .refclk(refclk), .div_n(div_n),
      .divclk(divclk_b), .ref_period(ref_period_b), .win_valid(win_valid_b),
      .locked(locked_b), .lock_state(lock_state_b)
   );

   always #5 ck = ~ck;

   // refclk generator: every 32 periods, |ref_delta| of them are 1 ck longer/shorter.
   int ref_base = 4;
   int ref_delta = 0;
   bit ref_stop = 1'b0;
   int rph = 0;
   int ridx = 0;
   int cur_per = 4;

   always @(negedge ck) begin
      if (ref_stop) begin
         refclk = 1'b0;
         rph = 0;
      end else begin
         if (rph == 0) begin
            cur_per = ref_base;
            if (ref_delta > 0 && ridx < ref_delta) cur_per = cur_per + 1;
            else if (ref_delta < 0 && ridx < -ref_delta) cur_per = cur_per - 1;
            ridx = (ridx + 1) % 32;
         end
         refclk = (rph < cur_per / 2);
         rph = (rph + 1 == cur_per) ? 0 : rph + 1;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] period;
      bit          chk_p;
      lock_state_t st;
      logic        lk;
   } exp_t;

   exp_t sbq[$];

   task automatic push_exp(input int period, input bit chk_p, input lock_state_t st, input logic lk);
      exp_t e;
      e.period = 16'(period);
      e.chk_p  = chk_p;
      e.st     = st;
      e.lk     = lk;
      sbq.push_back(e);
   endtask

   // Pop one expectation per DUT-A window; FSM outcome is checked one cycle later.
   task automatic drain(input int budget, input string tag);
      int   t;
      bit   pend;
      exp_t cur;
      t = 0;
      pend = 1'b0;
      while ((sbq.size() > 0 || pend) && t < budget) begin
         @(negedge ck);
         t++;
         if (pend) begin
            chk({tag, " state"}, 32'(lock_state_a), 32'(cur.st));
            chk({tag, " locked"}, 32'(locked_a), 32'(cur.lk));
            pend = 1'b0;
         end
         if (win_valid_a) begin
            if (sbq.size() == 0) begin
               chk({tag, " extra window"}, 32'(win_valid_a), 32'd0);
            end else begin
               cur = sbq.pop_front();
               if (cur.chk_p) chk({tag, " ref_period"}, 32'(ref_period_a), 32'(cur.period));
               pend = 1'b1;
            end
         end
      end
      chk({tag, " windows outstanding"}, 32'(sbq.size()) + 32'(pend), 32'd0);
      sbq.delete();
   endtask

   task automatic wait_win_b(input int budget, output bit seen);
      int t;
      t = 0;
      seen = 1'b0;
      while (!seen && t < budget) begin
         @(negedge ck);
         t++;
         if (win_valid_b) seen = 1'b1;
      end
   endtask

   task automatic meas_div(output int hi, output int lo);
      int t;
      hi = 0;
      lo = 0;
      t = 0;
      while (divclk_a !== 1'b0 && t < 100) begin @(negedge ck); t++; end
      while (divclk_a !== 1'b1 && t < 100) begin @(negedge ck); t++; end
      while (divclk_a === 1'b1 && t < 100) begin hi++; @(negedge ck); t++; end
      while (divclk_a === 1'b0 && t < 100) begin lo++; @(negedge ck); t++; end
   endtask

   // Mid-run reset (en left as is) for 3 cycles, then a clean idle gap before enabling.
   task automatic restart(input logic [7:0] dn, input int base, input int delta, input bit use_b);
      @(negedge ck);
      rst = 1'b1;
      div_n = dn;
      ref_base = base;
      ref_delta = delta;
      ref_stop = 1'b0;
      @(negedge ck);
      chk("rst divclk", 32'(divclk_a), 32'd0);
      chk("rst ref_period", 32'(ref_period_a), 32'd0);
      chk("rst win_valid", 32'(win_valid_a), 32'd0);
      chk("rst locked", 32'(locked_a), 32'd0);
      chk("rst lock_state", 32'(lock_state_a), 32'(LS_IDLE));
      chk("rst b ref_period", 32'(ref_period_b), 32'd0);
      chk("rst b divclk", 32'(divclk_b), 32'd0);
      repeat (2) @(negedge ck);
      rst = 1'b0;
      en_a = 1'b0;
      en_b = 1'b0;
      repeat (8) @(negedge ck);
      en_a = !use_b;
      en_b = use_b;
   endtask

   typedef struct {
      logic [7:0] dn;
      int         base;
      int         delta;
      int         period;
      bit         good;
   } vec_t;

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      int   hi, lo, n;
      bit   seen;

      vecs[0] = '{8'd4, 4,  0, 128, 1'b1};
      vecs[1] = '{8'd4, 4, -2, 126, 1'b1};
      vecs[2] = '{8'd4, 4,  2, 130, 1'b1};
      vecs[3] = '{8'd4, 4, -3, 125, 1'b0};
      vecs[4] = '{8'd4, 4,  3, 131, 1'b0};
      vecs[5] = '{8'd5, 5,  0, 160, 1'b1};
      vecs[6] = '{8'd4, 5,  0, 160, 1'b0};
      vecs[7] = '{8'd0, 2,  0,  64, 1'b1};
      vecs[8] = '{8'd1, 2,  0,  64, 1'b1};
      vecs[9] = '{8'd3, 3,  0,  96, 1'b1};

      repeat (3) @(negedge ck);

      foreach (vecs[i]) begin
         restart(vecs[i].dn, vecs[i].base, vecs[i].delta, 1'b0);
         for (int k = 0; k < 4; k++)
            push_exp(vecs[i].period, 1'b1,
                     (vecs[i].good && k == 3) ? LS_LOCK : LS_ACQ,
                     vecs[i].good && k == 3);
         @(negedge ck);
         chk("en -> ACQ", 32'(lock_state_a), 32'(LS_ACQ));
         meas_div(hi, lo);
         n = (vecs[i].dn < 8'd2) ? 2 : int'(vecs[i].dn);
         chk($sformatf("div%0d high", vecs[i].dn), 32'(hi), 32'(n / 2));
         chk($sformatf("div%0d low", vecs[i].dn), 32'(lo), 32'(n - n / 2));
         drain(1500, $sformatf("vec%0d", i));
      end

      // Lock, then refclk slows to 5 ck: HOLD on first bad window, ACQ on second.
      restart(8'd4, 4, 0, 1'b0);
      for (int k = 0; k < 4; k++) push_exp(128, 1'b1, (k == 3) ? LS_LOCK : LS_ACQ, k == 3);
      drain(1500, "lock");
      ref_base = 5;
      push_exp(0,   1'b0, LS_HOLD, 1'b1);
      push_exp(160, 1'b1, LS_ACQ,  1'b0);
      push_exp(160, 1'b1, LS_ACQ,  1'b0);
      drain(1500, "unlock");

      // 8-bit counter instance: stopped refclk saturates, then rearms and relocks.
      restart(8'd4, 4, 0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         wait_win_b(400, seen);
         chk("b window seen", 32'(seen), 32'd1);
         chk("b ref_period", 32'(ref_period_b), 32'd128);
      end
      @(negedge ck);
      chk("b lock_state", 32'(lock_state_b), 32'(LS_LOCK));
      chk("b locked", 32'(locked_b), 32'd1);
      ref_stop = 1'b1;
      wait_win_b(600, seen);
      chk("b sat window seen", 32'(seen), 32'd1);
      chk("b sat ref_period", 32'(ref_period_b), 32'd255);
      @(negedge ck);
      chk("b sat lock_state", 32'(lock_state_b), 32'(LS_HOLD));
      chk("b sat locked", 32'(locked_b), 32'd1);
      wait_win_b(300, seen);
      chk("b disarmed no window", 32'(seen), 32'd0);
      ref_stop = 1'b0;
      wait_win_b(600, seen);
      chk("b rearm window seen", 32'(seen), 32'd1);
      chk("b rearm ref_period", 32'(ref_period_b), 32'd128);
      @(negedge ck);
      chk("b relock lock_state", 32'(lock_state_b), 32'(LS_LOCK));
      chk("b relock locked", 32'(locked_b), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
